// File: rtl/mem_line_bridge_pkg.sv
// Shared types and default geometry for the memory line bridge.
// Optional build macro: CRIT_WORD_FIRST_EN (critical-word-first refill).
package mem_bridge_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_BEATS  = 4;

    localparam int BEAT_IDX_W = $clog2(DEFAULT_BEATS);
    localparam int BYTE_OFF_W = $clog2(DEFAULT_DATA_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        WB_SEND,
        FILL_REQ,
        FILL_RECV
    } bridge_state_e;

    typedef logic [DEFAULT_BEATS-1:0][DEFAULT_DATA_W-1:0] line_t;

endpackage

// File: rtl/mem_line_bridge_if.sv
// Word-wide memory request / read-return bus between the bridge and main memory.
// The bridge side (master) issues requests; read returns have no backpressure.
interface mem_line_bridge_if
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_line_bridge_line_assembler.sv
// Refill line register: drops returned read beats into word slots (start+cnt) mod BEATS.
// The line keeps its contents until a later fill overwrites individual slots.
module line_assembler
    import mem_bridge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BEATS  = DEFAULT_BEATS,
    localparam int IDX_W = $clog2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [IDX_W-1:0]        start_off,
    input  logic                    recv_en,
    input  logic                    rvalid,
    input  logic [DATA_W-1:0]       rdata,
    output logic [BEATS*DATA_W-1:0] fill_line,
    output logic                    first_beat,
    output logic                    last_beat
);

    logic [IDX_W-1:0]              start_reg;
    logic [IDX_W-1:0]              cnt_reg;
    logic [BEATS-1:0][DATA_W-1:0]  line_reg;
    logic [IDX_W-1:0]              slot;
    logic                          wr_en;
    logic [BEATS-1:0]              slot_we;

    assign wr_en      = recv_en && rvalid;
    assign slot       = start_reg + cnt_reg;
    assign first_beat = wr_en && (cnt_reg == '0);
    assign last_beat  = wr_en && (cnt_reg == IDX_W'(BEATS - 1));

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            assign slot_we[gi] = wr_en && (slot == IDX_W'(gi));
            assign fill_line[gi*DATA_W +: DATA_W] = line_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            start_reg <= start_off;
            cnt_reg   <= '0;
        end else if (wr_en) begin
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_reg <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (slot_we[i]) begin
                    line_reg[i] <= rdata;
                end
            end
        end
    end

endmodule

// File: rtl/mem_line_bridge.sv
// Memory-side bridge: serialises dirty-line writebacks into word beats and gathers line refills.
// Optional build macro: CRIT_WORD_FIRST_EN (word-aligned fill request, wrapped beats, crit_valid).
module mem_line_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int BEATS  = DEFAULT_BEATS,
    localparam int IDX_W  = $clog2(BEATS),
    localparam int BOFF_W = $clog2(DATA_W / 8),
    localparam int LOFF_W = IDX_W + BOFF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_start,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [BEATS*DATA_W-1:0] wb_line,
    input  logic                    fill_start,
    input  logic [ADDR_W-1:0]       fill_addr,
    output logic [BEATS*DATA_W-1:0] fill_line,
    output logic                    fill_done,
    output logic                    wb_done,
    output logic                    busy,
`ifdef CRIT_WORD_FIRST_EN
    output logic                    crit_valid,
`endif
    mem_line_bridge_if.master       mem
);

    bridge_state_e                state_reg, state_next;
    logic [IDX_W-1:0]             beat_reg;
    logic [BEATS-1:0][DATA_W-1:0] wb_words_reg;
    logic [ADDR_W-LOFF_W-1:0]     wb_base_reg;
    logic [ADDR_W-BOFF_W-1:0]     fill_word_reg;
    logic                         fill_pending_reg;
    logic                         wb_done_reg;
    logic                         fill_done_reg;

    logic                         wb_last_hs;
    logic                         req_hs;
    logic                         first_beat;
    logic                         last_beat;
    logic [IDX_W-1:0]             start_off;
    logic [ADDR_W-1:0]            req_addr;
    logic                         unused_bits;

    logic                         mem_valid_c;
    logic                         mem_we_c;
    logic [ADDR_W-1:0]            mem_addr_c;
    logic [DATA_W-1:0]            mem_wdata_c;

`ifdef CRIT_WORD_FIRST_EN
    assign start_off   = fill_word_reg[IDX_W-1:0];
    assign req_addr    = {fill_word_reg, {BOFF_W{1'b0}}};
    assign crit_valid  = first_beat;
    assign unused_bits = ^{wb_addr[LOFF_W-1:0], fill_addr[BOFF_W-1:0]};
`else
    assign start_off   = '0;
    assign req_addr    = {fill_word_reg[ADDR_W-BOFF_W-1:IDX_W], {LOFF_W{1'b0}}};
    assign unused_bits = ^{wb_addr[LOFF_W-1:0], fill_addr[BOFF_W-1:0],
                           fill_word_reg[IDX_W-1:0], first_beat};
`endif

    assign wb_last_hs = (state_reg == WB_SEND) && mem.mem_ready &&
                        (beat_reg == IDX_W'(BEATS - 1));
    assign req_hs     = (state_reg == FILL_REQ) && mem.mem_ready;

    always_comb begin
        state_next  = state_reg;
        mem_valid_c = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state_reg)
            IDLE: begin
                // Writeback wins a simultaneous start so the victim leaves before its slot is refilled.
                if (wb_start) begin
                    state_next = WB_SEND;
                end else if (fill_start) begin
                    state_next = FILL_REQ;
                end
            end
            WB_SEND: begin
                mem_valid_c = 1'b1;
                mem_we_c    = 1'b1;
                mem_addr_c  = {wb_base_reg, beat_reg, {BOFF_W{1'b0}}};
                mem_wdata_c = wb_words_reg[beat_reg];
                if (wb_last_hs) begin
                    state_next = fill_pending_reg ? FILL_REQ : IDLE;
                end
            end
            FILL_REQ: begin
                mem_valid_c = 1'b1;
                mem_addr_c  = req_addr;
                if (req_hs) begin
                    state_next = FILL_RECV;
                end
            end
            FILL_RECV: begin
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            beat_reg         <= '0;
            wb_words_reg     <= '0;
            wb_base_reg      <= '0;
            fill_word_reg    <= '0;
            fill_pending_reg <= 1'b0;
            wb_done_reg      <= 1'b0;
            fill_done_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wb_done_reg   <= wb_last_hs;
            fill_done_reg <= last_beat;
            case (state_reg)
                IDLE: begin
                    fill_pending_reg <= 1'b0;
                    beat_reg         <= '0;
                    if (wb_start) begin
                        wb_words_reg     <= wb_line;
                        wb_base_reg      <= wb_addr[ADDR_W-1:LOFF_W];
                        fill_pending_reg <= fill_start;
                    end
                    if (fill_start) begin
                        fill_word_reg <= fill_addr[ADDR_W-1:BOFF_W];
                    end
                end
                WB_SEND: begin
                    if (mem.mem_ready) begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    line_assembler #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_line_assembler (
        .clk        (clk),
        .rst        (rst),
        .load       (req_hs),
        .start_off  (start_off),
        .recv_en    (state_reg == FILL_RECV),
        .rvalid     (mem.mem_rvalid),
        .rdata      (mem.mem_rdata),
        .fill_line  (fill_line),
        .first_beat (first_beat),
        .last_beat  (last_beat)
    );

    assign mem.mem_valid = mem_valid_c;
    assign mem.mem_we    = mem_we_c;
    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;
    assign wb_done       = wb_done_reg;
    assign fill_done     = fill_done_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_line_bridge.sv
// Directed bench for mem_line_bridge: table of writeback/fill vectors plus backpressure,
// simultaneous-start and reset-during-fill sequences. Honours CRIT_WORD_FIRST_EN if defined.
module tb_mem_line_bridge;
    import mem_bridge_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_start;
    logic [31:0]  wb_addr;
    logic [127:0] wb_line;
    logic         fill_start;
    logic [31:0]  fill_addr;
    logic [127:0] fill_line;
    logic         fill_done;
    logic         wb_done;
    logic         busy;
`ifdef CRIT_WORD_FIRST_EN
    logic         crit_valid;
`endif

    mem_line_bridge_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    always #5 clk = ~clk;

    mem_line_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .wb_start   (wb_start),
        .wb_addr    (wb_addr),
        .wb_line    (wb_line),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_line  (fill_line),
        .fill_done  (fill_done),
        .wb_done    (wb_done),
        .busy       (busy),
`ifdef CRIT_WORD_FIRST_EN
        .crit_valid (crit_valid),
`endif
        .mem        (mem_bus)
    );

    typedef struct {
        bit          is_fill;
        logic [31:0] addr;
        line_t       data;
        int          gap;
        line_t       exp_addr;  // wb: beat addresses; fill: [0] = request address
        line_t       exp_data;  // wb: beat data; fill: expected fill_line
    } vec_t;

    vec_t vecs[4];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_run(input string tag, input logic [31:0] addr, input line_t data,
                          input int stall_beat, input int stall_n, input bit with_fill,
                          input logic [31:0] faddr, input line_t exp_addr, input line_t exp_data);
        int hs;
        int cyc;
        int stall_left;
        wb_addr = addr;
        wb_line = data;
        wb_start = 1'b1;
        fill_start = with_fill;
        fill_addr = faddr;
        mem_bus.mem_ready = 1'b1;
        step();
        wb_start = 1'b0;
        fill_start = 1'b0;
        cyc = 1;
        hs = 0;
        stall_left = stall_n;
        while (hs < 4 && cyc < 40) begin
            chk($sformatf("%s_valid_c%0d", tag, cyc), mem_bus.mem_valid, 1'b1);
            chk($sformatf("%s_we_c%0d", tag, cyc), mem_bus.mem_we, 1'b1);
            chk($sformatf("%s_done_early_c%0d", tag, cyc), wb_done, 1'b0);
            chk($sformatf("%s_addr_c%0d", tag, cyc), mem_bus.mem_addr, exp_addr[hs]);
            chk($sformatf("%s_wdata_c%0d", tag, cyc), mem_bus.mem_wdata, exp_data[hs]);
            if (hs == stall_beat && stall_left > 0) begin
                mem_bus.mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_bus.mem_ready = 1'b1;
                hs++;
            end
            step();
            cyc++;
        end
        mem_bus.mem_ready = 1'b1;
        chk($sformatf("%s_handshakes", tag), hs, 4);
        chk($sformatf("%s_done_cycle", tag), cyc, 5 + stall_n);
        chk($sformatf("%s_wb_done", tag), wb_done, 1'b1);
        chk($sformatf("%s_busy_after", tag), busy, with_fill);
        $display("wb %s addr=%08h stall=%0d done at cycle %0d", tag, addr, stall_n, cyc);
        if (!with_fill) begin
            step();
            chk($sformatf("%s_wb_done_pulse", tag), wb_done, 1'b0);
        end
    endtask

    task automatic fill_run(input string tag, input bit do_start, input logic [31:0] faddr,
                            input line_t data, input int gap, input logic [31:0] exp_req,
                            input line_t exp_line);
        if (do_start) begin
            fill_addr = faddr;
            fill_start = 1'b1;
            mem_bus.mem_ready = 1'b1;
            step();
            fill_start = 1'b0;
        end
        chk($sformatf("%s_req_valid", tag), mem_bus.mem_valid, 1'b1);
        chk($sformatf("%s_req_we", tag), mem_bus.mem_we, 1'b0);
        chk($sformatf("%s_req_addr", tag), mem_bus.mem_addr, exp_req);
        chk($sformatf("%s_req_busy", tag), busy, 1'b1);
        mem_bus.mem_ready = 1'b1;
        step();
        chk($sformatf("%s_recv_valid", tag), mem_bus.mem_valid, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk($sformatf("%s_done_early_b%0d", tag, b), fill_done, 1'b0);
                step();
            end
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata = data[b];
`ifdef CRIT_WORD_FIRST_EN
            #1;
            chk($sformatf("%s_crit_b%0d", tag, b), crit_valid, (b == 0));
`endif
            chk($sformatf("%s_done_early2_b%0d", tag, b), fill_done, 1'b0);
            step();
            mem_bus.mem_rvalid = 1'b0;
        end
        chk($sformatf("%s_fill_done", tag), fill_done, 1'b1);
        chk($sformatf("%s_fill_line", tag), fill_line, exp_line);
        chk($sformatf("%s_busy_after", tag), busy, 1'b0);
        $display("fill %s addr=%08h line=%032h", tag, faddr, fill_line);
        step();
        chk($sformatf("%s_fill_done_pulse", tag), fill_done, 1'b0);
        chk($sformatf("%s_fill_line_hold", tag), fill_line, exp_line);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        line_t w0;
        line_t c_line;
        line_t d_line;
        line_t d_exp;
        logic [31:0] d_req;

        // Writeback vectors.
        vecs[0] = '{1'b0, 32'h0000_1230, {32'h44, 32'h33, 32'h22, 32'h11}, 0,
                    {32'h0000_123C, 32'h0000_1238, 32'h0000_1234, 32'h0000_1230},
                    {32'h44, 32'h33, 32'h22, 32'h11}};
        vecs[1] = '{1'b0, 32'h0000_5A7C, {32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h1234_5678, 32'hDEAD_BEEF}, 0,
                    {32'h0000_5A7C, 32'h0000_5A78, 32'h0000_5A74, 32'h0000_5A70},
                    {32'hCAFE_F00D, 32'h0BAD_CAFE, 32'h1234_5678, 32'hDEAD_BEEF}};
        // Fill vectors: data[b] is the b-th returned beat.
`ifdef CRIT_WORD_FIRST_EN
        vecs[2] = '{1'b1, 32'h0000_2008, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2,
                    {96'h0, 32'h0000_2008}, {32'hA1, 32'hA0, 32'hA3, 32'hA2}};
        vecs[3] = '{1'b1, 32'hFFFF_FFF4, {32'h4, 32'h3, 32'h2, 32'h1}, 0,
                    {96'h0, 32'hFFFF_FFF4}, {32'h3, 32'h2, 32'h1, 32'h4}};
        d_req = 32'h0000_4004;
        d_exp = {32'hD2, 32'hD1, 32'hD0, 32'hD3};
`else
        vecs[2] = '{1'b1, 32'h0000_2008, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2,
                    {96'h0, 32'h0000_2000}, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[3] = '{1'b1, 32'hFFFF_FFF4, {32'h4, 32'h3, 32'h2, 32'h1}, 0,
                    {96'h0, 32'hFFFF_FFF0}, {32'h4, 32'h3, 32'h2, 32'h1}};
        d_req = 32'h0000_4000;
        d_exp = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
`endif
        w0     = {32'h44, 32'h33, 32'h22, 32'h11};
        c_line = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        d_line = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

        rst = 1'b1;
        wb_start = 1'b0;
        wb_addr = '0;
        wb_line = '0;
        fill_start = 1'b0;
        fill_addr = '0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata = '0;
        step();
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_valid", mem_bus.mem_valid, 1'b0);
        chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
        chk("rst_fill_line", fill_line, 128'h0);
        chk("rst_wb_done", wb_done, 1'b0);
        chk("rst_fill_done", fill_done, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].is_fill) begin
                wb_run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, -1, 0, 1'b0, 32'h0,
                       vecs[i].exp_addr, vecs[i].exp_data);
            end else begin
                fill_run($sformatf("vec%0d", i), 1'b1, vecs[i].addr, vecs[i].data, vecs[i].gap,
                         vecs[i].exp_addr[0], vecs[i].exp_data);
            end
        end

        // Backpressure: beat 1 stalled for three cycles.
        wb_run("stall", 32'h0000_1230, w0, 1, 3, 1'b0, 32'h0, vecs[0].exp_addr, w0);

        // Simultaneous start: all write beats, then the read request, wb_done before fill_done.
        wb_run("simul_wb", 32'h0000_1230, w0, -1, 0, 1'b1, 32'h0000_4004, vecs[0].exp_addr, w0);
        fill_run("simul_fill", 1'b0, 32'h0000_4004, d_line, 0, d_req, d_exp);

        // Reset after two of four fill beats.
        fill_addr = 32'h0000_3000;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        step();
        for (int b = 0; b < 2; b++) begin
            mem_bus.mem_rvalid = 1'b1;
            mem_bus.mem_rdata = 32'h55 + b;
            step();
        end
        mem_bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mem_valid", mem_bus.mem_valid, 1'b0);
        chk("midrst_mem_addr", mem_bus.mem_addr, 32'h0);
        chk("midrst_fill_line", fill_line, 128'h0);
        chk("midrst_fill_done", fill_done, 1'b0);
        step();
        step();
        rst = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_bus.mem_rvalid = (b < 2);
            mem_bus.mem_rdata = 32'h77;
            step();
            chk($sformatf("postrst_fill_done_%0d", b), fill_done, 1'b0);
            chk($sformatf("postrst_busy_%0d", b), busy, 1'b0);
        end
        mem_bus.mem_rvalid = 1'b0;
        $display("reset during fill: transfer abandoned");
        fill_run("after_rst", 1'b1, 32'h0000_3000, c_line, 1, 32'h0000_3000, c_line);

        // Stray read-return beat in IDLE must not touch fill_line.
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0BAD;
        step();
        mem_bus.mem_rvalid = 1'b0;
        step();
        chk("stray_fill_line", fill_line, c_line);
        chk("stray_fill_done", fill_done, 1'b0);
        chk("stray_busy", busy, 1'b0);
        $display("stray rvalid in idle: fill_line=%032h", fill_line);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_line_bridge.md
Name: mem_line_bridge

Overview:
- Memory-side stage directly downstream of the cache data array.
- Serialises an evicted dirty line (4x32) into single-word write beats to main memory.
- Issues a line read and gathers the returned word beats into a line for the data array refill path.
- Cache controller drives the start pulses; the bridge reports completion with one-cycle done pulses.

Parameters:
- DATA_W, 32, memory beat / word width
- ADDR_W, 32, byte address width
- BEATS, 4, words per cache line; power of two

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wb_start  in  1  pulse: capture wb_line and wb_addr, start writeback
- wb_addr  in  ADDR_W  line base address of victim; low log2(BEATS)+2 bits ignored
- wb_line  in  BEATS*DATA_W  victim line; word i at bits [i*DATA_W +: DATA_W]
- fill_start  in  1  pulse: start line refill
- fill_addr  in  ADDR_W  miss address; word offset used only with the optional feature
- fill_line  out  BEATS*DATA_W  assembled refill line, same word packing as wb_line
- fill_done  out  1  one-cycle pulse: fill_line complete and valid
- wb_done  out  1  one-cycle pulse: all writeback beats accepted
- busy  out  1  high whenever the FSM is not in IDLE
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request when mem_valid && mem_ready
- mem_we  out  1  1 = write beat, 0 = line read request
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write beat data
- mem_rvalid  in  1  read-return beat valid; no backpressure
- mem_rdata  in  DATA_W  read-return data

Behaviour:
- Reset: rst asynchronous, active-high. While asserted, FSM goes to IDLE and all outputs are 0, including fill_line. Reset mid-transfer abandons the transfer; no done pulse is produced.
- FSM states:
  - IDLE: clears pending flags; waits for a start pulse.
  - WB_SEND: sends write beats.
  - FILL_REQ: issues the line read request.
  - FILL_RECV: collects returned read beats.
- Transitions:
  - IDLE with wb_start: capture wb_line and base address, then WB_SEND. If fill_start is also high in that cycle, latch fill_pending and fill_addr.
  - IDLE with fill_start only: go to FILL_REQ.
  - Start pulses outside IDLE are ignored. The controller must wait for busy=0.
- WB_SEND:
  - Drives mem_valid=1, mem_we=1, mem_addr = base + beat*(DATA_W/8), mem_wdata = word[beat].
  - Beat advances only on the mem_valid && mem_ready handshake; address and data are held stable while mem_ready=0.
  - After beat BEATS-1 is accepted: wb_done pulses the next cycle, then go to FILL_REQ if fill_pending, else IDLE.
  - Writeback always precedes fill on simultaneous start, so the victim is written before its slot is refilled.
- FILL_REQ:
  - Drives mem_valid=1, mem_we=0, mem_addr = line base of fill_addr (word offset 0 without the optional feature).
  - On handshake go to FILL_RECV.
- FILL_RECV:
  - mem_valid=0. Each mem_rvalid beat writes word slot (start+cnt) mod BEATS; cnt is a wrap-around counter of log2(BEATS) bits.
  - After the BEATS-th beat: fill_done pulses the next cycle and the FSM returns to IDLE.
  - fill_line holds its value until the next fill's first beat overwrites a slot.
- mem_rvalid outside FILL_RECV is ignored and does not disturb fill_line.
- mem_valid is never dropped before its handshake.
- Latency with mem_ready always 1:
  - Writeback: BEATS cycles of beats, wb_done in cycle BEATS+1 after the start.
  - Fill: request in cycle 1 after the start, then memory latency plus BEATS beats, then a 1-cycle fill_done.

Optional Feature:
- Macro CRIT_WORD_FIRST_EN.
- Defined:
  - FILL_REQ drives the full word-aligned fill_addr.
  - start = word offset of fill_addr; returned beats wrap from the critical word (offset 2 → slots 2,3,0,1).
  - Added output port crit_valid, a 1-cycle pulse on the cycle the first beat is written. It lets the controller forward the missed word early.
- Undefined: start=0, the request address is line-aligned, and the crit_valid port is absent.

Decomposition:
- Package mem_bridge_pkg:
  - bridge_state_e enum (IDLE, WB_SEND, FILL_REQ, FILL_RECV)
  - localparams BEAT_IDX_W = $clog2(BEATS) and BYTE_OFF_W = $clog2(DATA_W/8)
  - line_t typedef: packed [BEATS-1:0][DATA_W-1:0]
- One natural sub-module: line_assembler, which holds the fill_line register, the slot counter and the wrap-around indexing. The top-level keeps the FSM and the write serialiser.

Test Plan:
- Writeback, mem_ready=1:
  - Stimulus: wb_addr=0x0000_1230, words 0x11,0x22,0x33,0x44.
  - Response: writes to 0x1230/0x1234/0x1238/0x123C with those data; wb_done in cycle 5; busy back to 0.
- Backpressure:
  - Stimulus: same writeback with mem_ready low for 3 cycles on beat 1.
  - Response: mem_addr=0x1234 and mem_wdata=0x22 held stable through the stall; exactly 4 handshakes; one wb_done.
- Fill:
  - Stimulus: fill_addr=0x0000_2008; return 0xA0,0xA1,0xA2,0xA3 with 2-cycle gaps.
  - Response: read request to 0x2000; fill_line words[0..3]=A0..A3; single fill_done.
- Simultaneous start:
  - Stimulus: wb_start and fill_start in the same cycle.
  - Response: all 4 write beats complete before the read request; wb_done precedes fill_done.
- Reset during fill:
  - Stimulus: rst asserted after 2 of 4 beats.
  - Response: outputs immediately 0, no fill_done; a subsequent fill completes normally. Stray mem_rvalid in IDLE leaves fill_line unchanged.
- With CRIT_WORD_FIRST_EN:
  - Stimulus: fill_addr=0x2008, beats B0..B3.
  - Response: request address 0x2008; slots 2,3,0,1 = B0,B1,B2,B3; crit_valid pulses with B0.
